// File: rtl/rggen_register_array_file.sv
// Register array: ARRAY_SIZE entries of ENTRY_BYTE_WIDTH bytes behind a valid/ready bus.
// Multi-word entries are written through a write buffer and read through a snapshot.
module rggen_register_array_file #(
  parameter int                              ADDRESS_WIDTH    = 8,
  parameter int                              BUS_WIDTH        = 32,
  parameter int                              BYTE_OFFSET      = 'h30,
  parameter int                              ENTRY_BYTE_WIDTH = 8,
  parameter int                              ARRAY_SIZE       = 4,
  parameter logic [ENTRY_BYTE_WIDTH*8-1:0]   WRITE_MASK       = '1,
  parameter logic [ENTRY_BYTE_WIDTH*8-1:0]   INITIAL_VALUE    = '0,
  parameter bit                              ATOMIC           = 1'b1
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_req_valid,
  output logic                                   o_req_ready,
  input  logic                                   i_req_write,
  input  logic [ADDRESS_WIDTH-1:0]               i_req_address,
  input  logic [BUS_WIDTH-1:0]                   i_req_wdata,
  input  logic [BUS_WIDTH/8-1:0]                 i_req_strobe,
  output logic                                   o_rsp_valid,
  input  logic                                   i_rsp_ready,
  output logic [1:0]                             o_rsp_status,
  output logic [BUS_WIDTH-1:0]                   o_rsp_rdata,
  output logic [ARRAY_SIZE*ENTRY_BYTE_WIDTH*8-1:0] o_value
);

  localparam int BUS_BYTES  = BUS_WIDTH / 8;
  localparam int ENTRY_BITS = ENTRY_BYTE_WIDTH * 8;
  localparam int WORDS      = ENTRY_BITS / BUS_WIDTH;
  localparam int WORD_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int IDX_W      = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam bit USE_ATOMIC = ATOMIC && (WORDS > 1);

  localparam logic [1:0] STATUS_OKAY   = 2'b00;
  localparam logic [1:0] STATUS_SLVERR = 2'b10;

  typedef enum logic {
    IDLE,
    RESPOND
  } state_e;

  state_e state_q, state_d;

  logic [ARRAY_SIZE-1:0][ENTRY_BITS-1:0] value_q;
  logic [ENTRY_BITS-1:0]                 wbuf_q;
  logic [IDX_W-1:0]                      wbuf_idx_q;
  logic                                  wbuf_valid_q;
  logic [ENTRY_BITS-1:0]                 snap_q;
  logic [IDX_W-1:0]                      snap_idx_q;
  logic                                  snap_valid_q;
  logic [1:0]                            status_q;
  logic [BUS_WIDTH-1:0]                  rdata_q;

  logic                  accept;
  logic [31:0]           addr_ext;
  logic [31:0]           offset;
  logic                  hit;
  logic [IDX_W-1:0]      idx;
  logic [WORD_W-1:0]     word;
  logic                  is_commit;
  logic                  buf_hit;
  logic                  snap_hit;
  logic [ENTRY_BITS-1:0] write_mask;
  logic [ENTRY_BITS-1:0] live_entry;
  logic [ENTRY_BITS-1:0] base_entry;
  logic [ENTRY_BITS-1:0] new_entry;
  logic [BUS_WIDTH-1:0]  mask_word;
  logic [BUS_WIDTH-1:0]  bit_en;
  logic [BUS_WIDTH-1:0]  base_word;
  logic [BUS_WIDTH-1:0]  live_word;
  logic [BUS_WIDTH-1:0]  snap_word;
  logic [BUS_WIDTH-1:0]  read_word;

  assign write_mask   = WRITE_MASK;
  assign o_value      = value_q;
  assign o_rsp_status = status_q;
  assign o_rsp_rdata  = rdata_q;
  assign accept       = i_req_valid && o_req_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_d = RESPOND;
      end
      RESPOND: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    addr_ext  = 32'(i_req_address) & ~32'(BUS_BYTES - 1);
    hit       = (addr_ext >= 32'(BYTE_OFFSET)) &&
                (addr_ext <  32'(BYTE_OFFSET + ARRAY_SIZE * ENTRY_BYTE_WIDTH));
    offset    = addr_ext - 32'(BYTE_OFFSET);
    idx       = IDX_W'(offset / 32'(ENTRY_BYTE_WIDTH));
    word      = WORD_W'((offset % 32'(ENTRY_BYTE_WIDTH)) / 32'(BUS_BYTES));
    is_commit = !USE_ATOMIC || (word == WORD_W'(WORDS - 1));
  end

  // The buffer starts as a copy of the live entry, so a commit can write the whole
  // buffer image; the live entry cannot change while the buffer is valid.
  always_comb begin
    live_entry = value_q[idx];
    buf_hit    = wbuf_valid_q && (wbuf_idx_q == idx);
    snap_hit   = snap_valid_q && (snap_idx_q == idx);
    base_entry = (USE_ATOMIC && buf_hit) ? wbuf_q : live_entry;
    mask_word  = write_mask[word*BUS_WIDTH +: BUS_WIDTH];
    bit_en     = '0;
    for (int unsigned b = 0; b < BUS_BYTES; b++) begin
      bit_en[b*8 +: 8] = {8{i_req_strobe[b]}};
    end
    bit_en     = bit_en & mask_word;
    base_word  = base_entry[word*BUS_WIDTH +: BUS_WIDTH];
    new_entry  = base_entry;
    new_entry[word*BUS_WIDTH +: BUS_WIDTH] = (base_word & ~bit_en) | (i_req_wdata & bit_en);
    live_word  = live_entry[word*BUS_WIDTH +: BUS_WIDTH];
    snap_word  = snap_q[word*BUS_WIDTH +: BUS_WIDTH];
    read_word  = (USE_ATOMIC && (word != '0) && snap_hit) ? snap_word : live_word;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      value_q      <= {ARRAY_SIZE{INITIAL_VALUE}};
      wbuf_q       <= '0;
      wbuf_idx_q   <= '0;
      wbuf_valid_q <= 1'b0;
      snap_q       <= '0;
      snap_idx_q   <= '0;
      snap_valid_q <= 1'b0;
      status_q     <= STATUS_OKAY;
      rdata_q      <= '0;
    end else if (accept) begin
      if (!hit) begin
        status_q <= STATUS_SLVERR;
        rdata_q  <= '0;
      end else if (i_req_write) begin
        status_q <= STATUS_OKAY;
        rdata_q  <= '0;
        if (is_commit) begin
          value_q[idx] <= new_entry;
          wbuf_valid_q <= 1'b0;
          if (snap_hit) snap_valid_q <= 1'b0;
        end else begin
          wbuf_q       <= new_entry;
          wbuf_idx_q   <= idx;
          wbuf_valid_q <= 1'b1;
        end
      end else begin
        status_q <= STATUS_OKAY;
        rdata_q  <= read_word;
        if (USE_ATOMIC && (word == '0)) begin
          snap_q       <= live_entry;
          snap_idx_q   <= idx;
          snap_valid_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rggen_register_array_file.sv
// Self-checking bench for rggen_register_array_file: 4 x 64-bit entries at 0x30 on a 32-bit bus.
module tb_rggen_register_array_file;

  localparam logic [63:0] TB_MASK = '1;
  localparam logic [63:0] TB_INIT = '0;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_req_valid;
  logic         o_req_ready;
  logic         i_req_write;
  logic [7:0]   i_req_address;
  logic [31:0]  i_req_wdata;
  logic [3:0]   i_req_strobe;
  logic         o_rsp_valid;
  logic         i_rsp_ready;
  logic [1:0]   o_rsp_status;
  logic [31:0]  o_rsp_rdata;
  logic [255:0] o_value;

  rggen_register_array_file #(
    .ADDRESS_WIDTH    (8),
    .BUS_WIDTH        (32),
    .BYTE_OFFSET      ('h30),
    .ENTRY_BYTE_WIDTH (8),
    .ARRAY_SIZE       (4),
    .WRITE_MASK       (TB_MASK),
    .INITIAL_VALUE    (TB_INIT),
    .ATOMIC           (1'b1)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_write   (i_req_write),
    .i_req_address (i_req_address),
    .i_req_wdata   (i_req_wdata),
    .i_req_strobe  (i_req_strobe),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_status  (o_rsp_status),
    .o_rsp_rdata   (o_rsp_rdata),
    .o_value       (o_value)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: entry contents, pending low word for one entry, and a read snapshot.
  logic [63:0] m_ent [4];
  bit          pend_v;
  int          pend_idx;
  logic [31:0] pend_lo;
  bit          snap_v;
  int          snap_idx;
  logic [63:0] snap;
  bit          exp_busy;
  logic [1:0]  exp_status;
  logic [31:0] exp_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_ent[i] = TB_INIT;
    pend_v   = 0;
    pend_idx = 0;
    pend_lo  = '0;
    snap_v   = 0;
    snap_idx = 0;
    snap     = '0;
    exp_busy = 0;
    exp_status = 2'b00;
    exp_rdata  = '0;
  endtask

  task automatic model_access(input bit wr, input logic [7:0] addr,
                              input logic [31:0] wd, input logic [3:0] st);
    int a, idx, w;
    logic [31:0] en, hi, lo;
    logic [63:0] mask_v;
    mask_v   = TB_MASK;
    a        = int'(addr) & ~3;
    exp_busy = 1;
    if (a < 'h30 || a >= 'h50) begin
      exp_status = 2'b10;
      exp_rdata  = '0;
    end else begin
      idx = (a - 'h30) / 8;
      w   = ((a - 'h30) % 8) / 4;
      exp_status = 2'b00;
      exp_rdata  = '0;
      for (int b = 0; b < 4; b++) en[b*8 +: 8] = {8{st[b]}};
      en = en & mask_v[w*32 +: 32];
      if (wr) begin
        if (w == 0) begin
          if (!(pend_v && pend_idx == idx)) begin
            pend_v   = 1;
            pend_idx = idx;
            pend_lo  = m_ent[idx][31:0];
          end
          pend_lo = (pend_lo & ~en) | (wd & en);
        end else begin
          hi = (m_ent[idx][63:32] & ~en) | (wd & en);
          lo = (pend_v && pend_idx == idx) ? pend_lo : m_ent[idx][31:0];
          m_ent[idx] = {hi, lo};
          pend_v = 0;
          if (snap_v && snap_idx == idx) snap_v = 0;
        end
      end else if (w == 0) begin
        exp_rdata = m_ent[idx][31:0];
        snap      = m_ent[idx];
        snap_v    = 1;
        snap_idx  = idx;
      end else begin
        exp_rdata = (snap_v && snap_idx == idx) ? snap[63:32] : m_ent[idx][63:32];
      end
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      chk("req_ready", {63'd0, o_req_ready}, {63'd0, !exp_busy});
      chk("rsp_valid", {63'd0, o_rsp_valid}, {63'd0, exp_busy});
      if (exp_busy) begin
        chk("rsp_status", {62'd0, o_rsp_status}, {62'd0, exp_status});
        chk("rsp_rdata", {32'd0, o_rsp_rdata}, {32'd0, exp_rdata});
      end
      for (int i = 0; i < 4; i++) chk("entry_value", o_value[i*64 +: 64], m_ent[i]);
    end
  end

  task automatic issue(input bit wr, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [3:0] st);
    @(negedge i_clk);
    i_req_valid   = 1'b1;
    i_req_write   = wr;
    i_req_address = addr;
    i_req_wdata   = wd;
    i_req_strobe  = st;
    @(posedge i_clk);
    model_access(wr, addr, wd, st);
    #1 i_req_valid = 1'b0;
  endtask

  task automatic collect(output logic [1:0] status, output logic [31:0] rdata);
    @(negedge i_clk);
    status      = o_rsp_status;
    rdata       = o_rsp_rdata;
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    exp_busy = 0;
    #1 i_rsp_ready = 1'b0;
  endtask

  task automatic do_req(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, output logic [1:0] status,
                        output logic [31:0] rdata);
    issue(wr, addr, wd, st);
    collect(status, rdata);
  endtask

  logic [1:0]  st;
  logic [31:0] rd;

  initial begin
    i_rst_n       = 1'b0;
    i_req_valid   = 1'b0;
    i_req_write   = 1'b0;
    i_req_address = '0;
    i_req_wdata   = '0;
    i_req_strobe  = '0;
    i_rsp_ready   = 1'b0;
    model_reset();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    // Reset contents
    do_req(0, 8'h30, 0, 4'h0, st, rd);
    chk("t1_rd30_status", {62'd0, st}, 64'd0);
    chk("t1_rd30_data", {32'd0, rd}, 64'd0);
    do_req(0, 8'h34, 0, 4'h0, st, rd);
    chk("t1_rd34_status", {62'd0, st}, 64'd0);
    chk("t1_rd34_data", {32'd0, rd}, 64'd0);
    chk("t1_value", o_value[63:0] | o_value[127:64] | o_value[191:128] | o_value[255:192], 64'd0);

    // Buffered low word, committed with high word
    do_req(1, 8'h40, 32'h11111111, 4'hF, st, rd);
    chk("t2_entry2_unchanged", o_value[128 +: 64], 64'd0);
    do_req(1, 8'h44, 32'h22222222, 4'hF, st, rd);
    chk("t2_entry2_commit", o_value[128 +: 64], 64'h22222222_11111111);
    chk("t2_wr_rdata", {32'd0, rd}, 64'd0);

    // Buffer discarded by a write to another entry
    do_req(1, 8'h40, 32'h0000AAAA, 4'hF, st, rd);
    do_req(1, 8'h48, 32'h0000BBBB, 4'hF, st, rd);
    do_req(1, 8'h44, 32'h0000CCCC, 4'hF, st, rd);
    chk("t3_entry2", o_value[128 +: 64], 64'h0000CCCC_11111111);
    chk("t3_entry3", o_value[192 +: 64], 64'd0);

    // Snapshot invalidated by commit
    do_req(0, 8'h38, 0, 4'h0, st, rd);
    chk("t4_rd38", {32'd0, rd}, 64'd0);
    do_req(1, 8'h38, 32'h12345678, 4'hF, st, rd);
    do_req(1, 8'h3C, 32'h9ABCDEF0, 4'hF, st, rd);
    do_req(0, 8'h3C, 0, 4'h0, st, rd);
    chk("t4_rd3c", {32'd0, rd}, 64'h9ABCDEF0);
    chk("t4_entry1", o_value[64 +: 64], 64'h9ABCDEF0_12345678);
    do_req(1, 8'h4C, 32'h33333333, 4'hF, st, rd);
    chk("t4_entry3_top_only", o_value[192 +: 64], 64'h33333333_00000000);

    // Decode boundaries, strobes, misses leave buffer alone
    do_req(0, 8'h50, 0, 4'h0, st, rd);
    chk("t5_rd50_status", {62'd0, st}, 64'd2);
    chk("t5_rd50_data", {32'd0, rd}, 64'd0);
    do_req(0, 8'h2C, 0, 4'h0, st, rd);
    chk("t5_rd2c_status", {62'd0, st}, 64'd2);
    do_req(0, 8'h4F, 0, 4'h0, st, rd);
    chk("t5_rd4f_status", {62'd0, st}, 64'd0);
    chk("t5_rd4f_data", {32'd0, rd}, 64'h33333333);
    do_req(1, 8'h34, 32'hFFFFFFFF, 4'b0001, st, rd);
    chk("t5_strobe", o_value[0 +: 64], 64'h000000FF_00000000);
    do_req(1, 8'h30, 32'h5A5A5A5A, 4'hF, st, rd);
    do_req(1, 8'h50, 32'hDEADBEEF, 4'hF, st, rd);
    chk("t5_wr50_status", {62'd0, st}, 64'd2);
    do_req(1, 8'h34, 32'h00000001, 4'hF, st, rd);
    chk("t5_entry0_after_miss", o_value[0 +: 64], 64'h00000001_5A5A5A5A);

    // Stalled response, then reset mid-wait
    do_req(1, 8'h30, 32'h00000077, 4'hF, st, rd);
    issue(0, 8'h3C, 0, 4'h0);
    repeat (5) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", {63'd0, o_req_ready}, 64'd1);
    chk("t6_rst_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
    chk("t6_rst_status", {62'd0, o_rsp_status}, 64'd0);
    chk("t6_rst_rdata", {32'd0, o_rsp_rdata}, 64'd0);
    chk("t6_rst_value", o_value[63:0] | o_value[127:64] | o_value[191:128] | o_value[255:192], 64'd0);
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    do_req(1, 8'h34, 32'h00000001, 4'hF, st, rd);
    chk("t6_buffer_cleared", o_value[0 +: 64], 64'h00000001_00000000);
    do_req(0, 8'h3C, 0, 4'h0, st, rd);
    chk("t6_entry1_cleared", {32'd0, rd}, 64'd0);

    repeat (2) @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
